graphite_cmd_master: RTL

Command-stream source for the `graphite` rasterizer: buffers 32-bit command words written by the host CPU in a FIFO and drives them out as an AXI-stream master into the rasterizer's `cmd_axis` slave port. It sits between the SoC register bus and `graphite`, decoupling host write bursts from rasterizer back-pressure, and reports fill level, idle, overflow and a transferred-word count back to the host.

---
 rtl/graphite_cmd_master.sv | 131 +++++++++++++
 1 files changed

// File: rtl/graphite_cmd_master.sv
// graphite_cmd_master
// Host-fed command FIFO that streams 32-bit command words to the graphite
// rasterizer over an AXI-stream master port. The FIFO absorbs host write
// bursts while the rasterizer applies back-pressure, and it reports fill
// level, idle, sticky overflow and a count of completed handshakes.
//
// All outputs are driven only from registered state: the stream head is
// read from the memory at the registered read pointer, and the status flags
// decode the registered level counter. Nothing reaches an output
// combinationally from wr_i or cmd_axis_tready_i.

module graphite_cmd_master #(
  parameter  int DEPTH = 16,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset_i,
  input  logic          wr_i,
  input  logic [31:0]   wr_data_i,
  input  logic          flush_i,
  output logic          full_o,
  output logic          idle_o,
  output logic [LW-1:0] level_o,
  output logic          overflow_o,
  output logic [31:0]   sent_count_o,
  output logic          cmd_axis_tvalid_o,
  input  logic          cmd_axis_tready_i,
  output logic [31:0]   cmd_axis_tdata_o
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  // Storage and control state. Pointers wrap naturally because DEPTH is a
  // power of two; the separate level counter removes the usual
  // full/empty ambiguity of comparing equal pointers.
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] rd_q,    rd_d;
  logic [AW-1:0] wr_q,    wr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q,   ovf_d;
  logic [31:0]   sent_q,  sent_d;

  // Status decoded from the level as it stood at the start of the cycle.
  logic full_now;
  logic empty_now;
  logic push;
  logic pop;
  logic push_drop;

  assign full_now  = (level_q == FULL_LVL);
  assign empty_now = (level_q == '0);

  // A write while full is rejected even if a pop frees a slot this same
  // cycle: fullness is judged on registered state only, which keeps the
  // write-enable free of any dependence on tready.
  assign push      = wr_i && !full_now;
  assign push_drop = wr_i &&  full_now;
  assign pop       = !empty_now && cmd_axis_tready_i;

  // Next-state for pointers, level, overflow and handshake count. Flush
  // wins over any same-cycle push or pop: the word is dropped, overflow is
  // not raised and the handshake is not counted.
  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    level_d = level_q;
    ovf_d   = ovf_q;
    sent_d  = sent_q;

    if (flush_i) begin
      rd_d    = '0;
      wr_d    = '0;
      level_d = '0;
      ovf_d   = 1'b0;
    end else begin
      if (push) begin
        wr_d = wr_q + AW'(1);
      end
      if (pop) begin
        rd_d   = rd_q + AW'(1);
        sent_d = sent_q + 32'd1;
      end
      if (push_drop) begin
        ovf_d = 1'b1;
      end
      case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Control registers; reset clears everything including the handshake
  // count, which flush deliberately leaves alone.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      sent_q  <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      sent_q  <= sent_d;
    end
  end

  // Word storage is datapath only and is never cleared; stale contents are
  // unreachable because the level counter gates tvalid.
  always_ff @(posedge clk) begin
    if (push && !flush_i && !reset_i) begin
      mem_q[wr_q] <= wr_data_i;
    end
  end

  // Outputs, all derived from registered state. The head word only moves
  // on a pop, so tdata stays stable while tvalid is held without tready.
  assign full_o            = full_now;
  assign idle_o            = empty_now;
  assign level_o           = level_q;
  assign overflow_o        = ovf_q;
  assign sent_count_o      = sent_q;
  assign cmd_axis_tvalid_o = !empty_now;
  assign cmd_axis_tdata_o  = mem_q[rd_q];

endmodule
